// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single synchronous ROM.
// Port 0 (display) always wins; port 1 runs preemptible bursts.
module rom_port_arbiter #(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 12,
    parameter int LEN_WIDTH    = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_start,
    input  logic [ADDR_WIDTH-1:0] p1_base,
    input  logic [LEN_WIDTH-1:0]  p1_len,
    output logic                  p1_busy,
    output logic                  p1_rvalid,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_starved,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        LAST  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } tag_t;

    state_t                state_q, state_d;
    tag_t                  tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic                  starved_q, starved_d;
    logic                  zdone_q, zdone_d;
    logic                  p1_issue;

    assign p1_issue = (state_q == BURST) && !p0_req;

    // Next-state: burst sequencing, starvation tracking, return tagging.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        starve_d  = starve_q;
        starved_d = starved_q;
        zdone_d   = 1'b0;
        tag_d     = TAG_NONE;
        if (p0_req) begin
            tag_d = TAG_P0;
        end else if (p1_issue) begin
            tag_d = TAG_P1;
        end
        unique case (state_q)
            IDLE: begin
                if (p1_start) begin
                    starved_d = 1'b0;
                    if (p1_len != '0) begin
                        addr_d  = p1_base;
                        rem_d   = p1_len;
                        state_d = BURST;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (p1_issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    rem_d    = rem_q - LEN_WIDTH'(1);
                    starve_d = '0;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = LAST;
                    end
                end else begin
                    if (starve_q != LIMIT) begin
                        starve_d = starve_q + CW'(1);
                    end
                    if (starve_d == LIMIT) begin
                        starved_d = 1'b1;
                    end
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tag_q     <= TAG_NONE;
            addr_q    <= '0;
            rem_q     <= '0;
            starve_q  <= '0;
            starved_q <= 1'b0;
            zdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            starve_q  <= starve_d;
            starved_q <= starved_d;
            zdone_q   <= zdone_d;
        end
    end

    // ROM request mux; port 0 bypasses the FSM entirely.
    always_comb begin
        rom_en   = 1'b0;
        rom_addr = '0;
        if (!rst) begin
            if (p0_req) begin
                rom_en   = 1'b1;
                rom_addr = p0_addr;
            end else if (p1_issue) begin
                rom_en   = 1'b1;
                rom_addr = addr_q;
            end
        end
    end

    assign p0_rvalid  = !rst && (tag_q == TAG_P0);
    assign p1_rvalid  = !rst && (tag_q == TAG_P1);
    assign p1_busy    = !rst && (state_q != IDLE);
    assign p1_done    = !rst && ((state_q == LAST) || zdone_q);
    assign p1_starved = !rst && starved_q;
    assign p0_rdata   = rom_dout;
    assign p1_rdata   = rom_dout;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomised bench for rom_port_arbiter against a
// transaction-level model (address queue per burst).
module tb_rom_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 12;
    localparam int LW = 8;
    localparam int SL = 8;

    logic          clk;
    logic          rst;
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_start;
    logic [AW-1:0] p1_base;
    logic [LW-1:0] p1_len;
    logic          p1_busy;
    logic          p1_rvalid;
    logic          p1_done;
    logic [DW-1:0] p1_rdata;
    logic          p1_starved;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;

    int n_vec;
    int n_err;

    rom_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .LEN_WIDTH   (LW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_start  (p1_start),
        .p1_base   (p1_base),
        .p1_len    (p1_len),
        .p1_busy   (p1_busy),
        .p1_rvalid (p1_rvalid),
        .p1_done   (p1_done),
        .p1_rdata  (p1_rdata),
        .p1_starved(p1_starved),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return DW'(a * 3) ^ DW'(a >> 5) ^ 12'hA5A;
    endfunction

    // Behavioural synchronous ROM, one cycle latency.
    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_f(rom_addr);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: pending burst addresses, plus what returns next cycle.
    int unsigned  m_q[$];
    bit           m_last;
    bit           m_zero;
    bit           m_starved;
    int           m_starve;
    bit           m_p0v;
    bit           m_p1v;
    logic [AW-1:0] m_p0a;
    logic [AW-1:0] m_p1a;

    task automatic cyc(input bit r, input bit req,
                       input logic [AW-1:0] pa,
                       input bit st,
                       input logic [AW-1:0] b,
                       input logic [LW-1:0] l);
        bit iss1;
        bit idle;
        bit en_e;
        logic [AW-1:0] ad_e;
        @(negedge clk);
        rst      = r;
        p0_req   = req;
        p0_addr  = pa;
        p1_start = st;
        p1_base  = b;
        p1_len   = l;
        #1;
        iss1 = !r && !req && (m_q.size() > 0);
        en_e = !r && (req || iss1);
        ad_e = '0;
        if (!r && req) ad_e = pa;
        else if (iss1) ad_e = AW'(m_q[0]);
        chk("rom_en", 32'(rom_en), 32'(en_e));
        chk("rom_addr", 32'(rom_addr), 32'(ad_e));
        chk("p1_busy", 32'(p1_busy),
            32'(!r && (m_q.size() > 0 || m_last)));
        chk("p0_rvalid", 32'(p0_rvalid), 32'(!r && m_p0v));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(!r && m_p1v));
        chk("p1_done", 32'(p1_done),
            32'(!r && (m_last || m_zero)));
        chk("p1_starved", 32'(p1_starved),
            32'(!r && m_starved));
        if (!r && m_p0v)
            chk("p0_rdata", 32'(p0_rdata), 32'(rom_f(m_p0a)));
        if (!r && m_p1v)
            chk("p1_rdata", 32'(p1_rdata), 32'(rom_f(m_p1a)));
        if (r) begin
            m_q.delete();
            m_last    = 0;
            m_zero    = 0;
            m_starved = 0;
            m_starve  = 0;
            m_p0v     = 0;
            m_p1v     = 0;
        end else begin
            idle  = (m_q.size() == 0) && !m_last;
            m_p0v = req;
            m_p0a = pa;
            m_p1v = iss1;
            m_last = 0;
            if (iss1) begin
                m_p1a    = AW'(m_q.pop_front());
                m_last   = (m_q.size() == 0);
                m_starve = 0;
            end else if (m_q.size() > 0 && req) begin
                if (m_starve < SL) m_starve++;
                if (m_starve == SL) m_starved = 1;
            end
            m_zero = idle && st && (l == 0);
            if (idle && st) begin
                m_starved = 0;
                for (int i = 0; i < int'(l); i++)
                    m_q.push_back((b + i) % (1 << AW));
            end
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, '0);
    endtask

    task automatic start(input logic [AW-1:0] b,
                         input logic [LW-1:0] l);
        cyc(0, 0, '0, 1, b, l);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_last    = 0;
        m_zero    = 0;
        m_starved = 0;
        m_starve  = 0;
        m_p0v     = 0;
        m_p1v     = 0;
        m_p0a     = '0;
        m_p1a     = '0;
        rst       = 1'b1;
        p0_req    = 1'b0;
        p0_addr   = '0;
        p1_start  = 1'b0;
        p1_base   = '0;
        p1_len    = '0;
        // reset with activity on every input
        cyc(1, 1, 17'h00123, 1, 17'h00040, 8'd3);
        cyc(1, 1, 17'h00456, 1, 17'h00050, 8'd2);
        idle_n(3);
        // wrap-around burst
        start(17'h1FFFE, 8'd4);
        idle_n(6);
        // preempted burst
        start(17'h00100, 8'd3);
        idle_n(1);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, AW'(17'h00900 + i), 0, '0, '0);
        idle_n(6);
        // zero-length burst
        start(17'h00777, 8'd0);
        idle_n(3);
        // starvation
        start(17'h00200, 8'd2);
        idle_n(1);
        for (int i = 0; i < SL; i++)
            cyc(0, 1, AW'(17'h00A00 + i), 0, '0, '0);
        idle_n(5);
        start(17'h00300, 8'd3);
        idle_n(6);
        // reset mid-burst
        start(17'h00400, 8'd6);
        idle_n(2);
        cyc(1, 0, '0, 0, '0, '0);
        idle_n(2);
        start(17'h00410, 8'd2);
        idle_n(4);
        // start ignored while busy
        start(17'h00500, 8'd4);
        idle_n(1);
        start(17'h00600, 8'd4);
        idle_n(6);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 35),
                AW'($urandom),
                ($urandom_range(0, 99) < 15),
                AW'($urandom_range(0, 3) == 0 ?
                    (17'h1FFFC + $urandom_range(0, 3)) : $urandom),
                LW'($urandom_range(0, 6)));
        end
        idle_n(10);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, meaning the ROM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 12, meaning the ROM word width (RGB444).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, meaning the burst length width.
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 1024, meaning the consecutive denied burst cycles before the starved flag sets.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port p0_req, input, 1 bit: display-path read request, high priority.
REQ-008 The block SHALL have port p0_addr, input, ADDR_WIDTH: display-path read address.
REQ-009 The block SHALL have ports p0_rvalid (output, 1 bit) and p0_rdata (output, DATA_WIDTH): display read return.
REQ-010 The block SHALL have port p1_start, input, 1 bit: single-cycle burst start pulse.
REQ-011 The block SHALL have ports p1_base (input, ADDR_WIDTH) and p1_len (input, LEN_WIDTH): burst start address and word count.
REQ-012 The block SHALL have ports p1_busy, p1_rvalid and p1_done (outputs, 1 bit each) and p1_rdata (output, DATA_WIDTH).
REQ-013 The block SHALL have port p1_starved, output, 1 bit: sticky starvation flag.
REQ-014 The block SHALL have ports rom_en (output, 1 bit), rom_addr (output, ADDR_WIDTH) and rom_dout (input, DATA_WIDTH): synchronous ROM port with 1-cycle read latency.

Function
REQ-015 When p0_req=1, the block SHALL drive rom_en=1 and rom_addr=p0_addr combinationally in the same cycle, regardless of FSM state.
REQ-016 The FSM SHALL have states IDLE, BURST and LAST; p1_busy SHALL be 1 exactly in BURST and LAST.
REQ-017 In IDLE, p1_start=1 with p1_len>0 SHALL latch cur_addr=p1_base and remaining=p1_len, and SHALL move the FSM to BURST.
REQ-018 In IDLE, p1_start=1 with p1_len=0 SHALL pulse p1_done for one cycle on the next cycle, issue no ROM read, and keep the FSM in IDLE.
REQ-019 p1_start SHALL be ignored in BURST and LAST.
REQ-020 In BURST, a cycle with p0_req=0 SHALL issue a port-1 read: rom_en=1, rom_addr=cur_addr, cur_addr increments modulo 2^ADDR_WIDTH, and remaining decrements.
REQ-021 In BURST, a cycle with p0_req=1 SHALL pause the burst and leave cur_addr and remaining unchanged.
REQ-022 The issue that brings remaining to 0 SHALL move the FSM to LAST; LAST SHALL move to IDLE unconditionally on the next cycle.
REQ-023 p1_done SHALL be 1 for one cycle in LAST, coincident with the final p1_rvalid.
REQ-024 When no read is issued, the block SHALL drive rom_en=0 and rom_addr=0.
REQ-025 A 2-bit source tag SHALL be registered at issue; p0_rvalid and p1_rvalid SHALL each assert exactly one cycle after the matching issue and never both in the same cycle.
REQ-026 p0_rdata and p1_rdata SHALL equal rom_dout; their values are defined only while the matching rvalid is 1.
REQ-027 Total port-1 rvalid pulses per burst SHALL equal p1_len, with returned data in ascending address order.
REQ-028 A starve counter SHALL increment on each BURST cycle with p0_req=1, saturate at STARVE_LIMIT, and clear on any port-1 issue.
REQ-029 p1_starved SHALL set when the starve counter reaches STARVE_LIMIT, and SHALL stay set until the next accepted p1_start or reset.

Reset
REQ-030 While rst=1, the block SHALL force state=IDLE, cur_addr=0, remaining=0, tag=none, starve counter=0.
REQ-031 While rst=1, the block SHALL drive p0_rvalid=0, p1_rvalid=0, p1_busy=0, p1_done=0, p1_starved=0, rom_en=0 and rom_addr=0.
REQ-032 A reset mid-burst SHALL abort the burst: no p1_done, no further p1_rvalid.
REQ-033 The block SHALL ignore p1_start in the reset cycle.

Verification
REQ-034 The bench SHALL cover this scenario: p1_start, base=0x1FFFE, len=4, p0_req=0 -> rom_addr 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 on consecutive cycles, 4 p1_rvalid, p1_done with the 4th.
REQ-035 The bench SHALL cover this scenario: burst len=3 with p0_req=1 for 5 cycles after the first issue -> p0 gets 5 p0_rvalid, the burst resumes at base+1, and p1_done occurs 5 cycles later than when unpreempted.
REQ-036 The bench SHALL cover this scenario: p1_start with len=0 -> p1_done pulse the next cycle, p1_busy stays 0, rom_en stays 0.
REQ-037 The bench SHALL cover this scenario: STARVE_LIMIT=8, burst active, p0_req=1 for 8 cycles -> p1_starved=1; it stays 1 after the burst completes and clears on the next accepted p1_start.
REQ-038 The bench SHALL cover this scenario: rst pulsed after 2 of 6 issues -> all outputs 0 the next cycle, no p1_done, and a new burst is accepted afterwards.
REQ-039 The bench SHALL cover this scenario: p1_start during BURST with a different base -> ignored, and the original burst completes unchanged.
